// File: rtl/register_file_pkg.sv
// Shared CPU constants and operand types for the rename-aware register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package register_file_pkg;

   localparam int NUM_REGS  = 32;
   localparam int REG_IDX_W = 5;
   localparam int DATA_W    = 32;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0]    data_t;

   // A resolved source operand: ready flag plus its value
   typedef struct packed {
      logic  ready;
      data_t value;
   } operand_t;

endpackage

// File: rtl/register_file_if.sv
// Bus between the register file, the instruction unit and the reorder buffer.
// Latency: n/a (wires only).
// Backpressure: none; readyIn is a global enable rather than a handshake.
interface register_file_if #(
   parameter int ROB_WIDTH = 4
) ();
   import register_file_pkg::*;

   // global control
   logic                 readyIn;
   logic                 clear;
   // commit write from the reorder buffer
   logic                 regUpdateValid;
   reg_idx_t             regUpdateDest;
   data_t                regValue;
   logic [ROB_WIDTH-1:0] regUpdateRobId;
   // rename from the instruction unit
   logic                 depValid;
   reg_idx_t             depReg;
   logic [ROB_WIDTH-1:0] depRobId;
   // source lookups
   reg_idx_t             rs1Reg;
   reg_idx_t             rs2Reg;
   logic [ROB_WIDTH-1:0] rs1Dep;
   logic [ROB_WIDTH-1:0] rs2Dep;
   logic                 robRs1Ready;
   logic                 robRs2Ready;
   data_t                robRs1Value;
   data_t                robRs2Value;
   logic                 rs1Ready;
   logic                 rs2Ready;
   data_t                rs1Value;
   data_t                rs2Value;

   // register file side
   modport slave (
      input  readyIn, clear,
      input  regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
      input  depValid, depReg, depRobId,
      input  rs1Reg, rs2Reg,
      output rs1Dep, rs2Dep,
      input  robRs1Ready, robRs2Ready, robRs1Value, robRs2Value,
      output rs1Ready, rs2Ready, rs1Value, rs2Value
   );

   // instruction unit / reorder buffer side
   modport master (
      output readyIn, clear,
      output regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
      output depValid, depReg, depRobId,
      output rs1Reg, rs2Reg,
      input  rs1Dep, rs2Dep,
      output robRs1Ready, robRs2Ready, robRs1Value, robRs2Value,
      input  rs1Ready, rs2Ready, rs1Value, rs2Value
   );

endinterface

// File: rtl/register_file.sv
// Architectural register file with per-register busy bit and ROB tag for renaming.
// Latency: reads are combinational; commit/rename/clear take effect at the next rising edge.
// Backpressure: none; readyIn low freezes all state while reads stay live.
module register_file
   import register_file_pkg::*;
#(
   parameter int ROB_WIDTH = 4
) (
   input  logic           clockIn,
   input  logic           resetIn,
   register_file_if.slave bus
);

   typedef logic [ROB_WIDTH-1:0] tag_t;

   data_t                value_q [NUM_REGS];
   data_t                value_d [NUM_REGS];
   logic  [NUM_REGS-1:0] busy_q;
   logic  [NUM_REGS-1:0] busy_d;
   tag_t                 tag_q   [NUM_REGS];
   tag_t                 tag_d   [NUM_REGS];

   logic     commit_en;
   logic     rename_en;
   logic     flush_en;
   operand_t rs1_res;
   operand_t rs2_res;

   // x0 is never written or renamed, so both enables exclude it here
   assign commit_en = bus.readyIn & bus.regUpdateValid & (bus.regUpdateDest != '0);
   assign rename_en = bus.readyIn & bus.depValid & ~bus.clear & (bus.depReg != '0);
   assign flush_en  = bus.readyIn & bus.clear;

   // One operand lookup. Bypass only applies to a busy register whose in-flight
   // commit carries exactly the tag it is waiting on; tags wrap, so only equality counts.
   function automatic operand_t resolve(
      input reg_idx_t idx,
      input logic     is_busy,
      input tag_t     tag,
      input data_t    stored,
      input logic     cm_vld,
      input reg_idx_t cm_dest,
      input tag_t     cm_tag,
      input data_t    cm_value,
      input logic     rob_ready,
      input data_t    rob_value
   );
      operand_t r;
      if (idx == '0) begin
         r.ready = 1'b1;
         r.value = '0;
      end else if (!is_busy) begin
         r.ready = 1'b1;
         r.value = stored;
      end else if (cm_vld && (cm_dest == idx) && (cm_tag == tag)) begin
         r.ready = 1'b1;
         r.value = cm_value;
      end else begin
         r.ready = rob_ready;
         r.value = rob_value;
      end
      return r;
   endfunction

   // Next state: commit value write, then flush, then rename (rename wins busy/tag)
   always_comb begin
      value_d = value_q;
      busy_d  = busy_q;
      tag_d   = tag_q;
      if (commit_en) begin
         value_d[bus.regUpdateDest] = bus.regValue;
         if (busy_q[bus.regUpdateDest] && (tag_q[bus.regUpdateDest] == bus.regUpdateRobId)) begin
            busy_d[bus.regUpdateDest] = 1'b0;
         end
      end
      if (flush_en) begin
         busy_d = '0;
      end
      if (rename_en) begin
         busy_d[bus.depReg] = 1'b1;
         tag_d[bus.depReg]  = bus.depRobId;
      end
      busy_d[0]  = 1'b0;
      value_d[0] = '0;
   end

   // State registers; asynchronous reset clears everything immediately
   always_ff @(posedge clockIn or negedge resetIn) begin
      if (!resetIn) begin
         busy_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
      end else begin
         value_q <= value_d;
         busy_q  <= busy_d;
         tag_q   <= tag_d;
      end
   end

   // Resolve both source operands from the same lookup function; sees pre-edge state only
   always_comb begin
      rs1_res = resolve(bus.rs1Reg, busy_q[bus.rs1Reg], tag_q[bus.rs1Reg], value_q[bus.rs1Reg],
                        commit_en, bus.regUpdateDest, bus.regUpdateRobId, bus.regValue,
                        bus.robRs1Ready, bus.robRs1Value);
      rs2_res = resolve(bus.rs2Reg, busy_q[bus.rs2Reg], tag_q[bus.rs2Reg], value_q[bus.rs2Reg],
                        commit_en, bus.regUpdateDest, bus.regUpdateRobId, bus.regValue,
                        bus.robRs2Ready, bus.robRs2Value);
   end

   assign bus.rs1Dep   = tag_q[bus.rs1Reg];
   assign bus.rs2Dep   = tag_q[bus.rs2Reg];
   assign bus.rs1Ready = rs1_res.ready;
   assign bus.rs1Value = rs1_res.value;
   assign bus.rs2Ready = rs2_res.ready;
   assign bus.rs2Value = rs2_res.value;

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 4, meaning the width of a reorder-buffer index.
REQ-002 SHALL have port clockIn, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetIn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port readyIn, input, 1 bit: global enable; when low, no state changes.
REQ-005 SHALL have port clear, input, 1 bit: mispredict flush from the reorder buffer.
REQ-006 SHALL have ports regUpdateValid (input, 1), regUpdateDest (input, 5), regValue (input, 32) and regUpdateRobId (input, ROB_WIDTH): the commit write from the reorder buffer.
REQ-007 SHALL have ports depValid (input, 1), depReg (input, 5) and depRobId (input, ROB_WIDTH): rename of destination depReg to ROB entry depRobId by the instruction unit.
REQ-008 SHALL have ports rs1Reg (input, 5) and rs2Reg (input, 5): source register indices.
REQ-009 SHALL have ports rs1Dep and rs2Dep (output, ROB_WIDTH): the ROB tag driven to the reorder buffer for lookup.
REQ-010 SHALL have ports robRs1Ready and robRs2Ready (input, 1), and robRs1Value and robRs2Value (input, 32): the reorder buffer's lookup response.
REQ-011 SHALL have ports rs1Ready and rs2Ready (output, 1), and rs1Value and rs2Value (output, 32): the resolved operands.

Function
REQ-012 SHALL hold 32x32-bit values plus, per register, a busy bit and a ROB_WIDTH tag; x0 SHALL always read 0, ready, and never become busy.
REQ-013 On a commit (readyIn & regUpdateValid & regUpdateDest!=0), value[dest] SHALL become regValue at the next edge.
REQ-014 On a commit, busy[dest] SHALL clear only if busy[dest] and tag[dest]==regUpdateRobId.
REQ-015 A rename (readyIn & depValid & !clear & depReg!=0) SHALL set busy[depReg]=1 and tag[depReg]=depRobId.
REQ-016 When a rename and a commit hit the same register in one cycle, the rename SHALL win busy and tag, and the value write SHALL still occur.
REQ-017 When readyIn & clear, all busy bits SHALL clear, a same-cycle rename SHALL be ignored, and a same-cycle commit value write SHALL still occur.
REQ-018 Reads SHALL be combinational (zero latency), per source independently.
REQ-019 A read of reg 0 SHALL give ready=1, value=0.
REQ-020 A read of a register that is not busy SHALL give ready=1, value=value[reg].
REQ-021 A read of a busy register whose commit is present this cycle (regUpdateValid, matching dest and tag) SHALL give ready=1, value=regValue (bypass).
REQ-022 Any other busy read SHALL give ready=robRsXReady, value=robRsXValue.
REQ-023 rsXDep SHALL always equal tag[rsXReg].
REQ-024 The read path SHALL NOT observe a same-cycle rename; the instruction unit resolves the rd==rs case itself.
REQ-025 The ROB tag space SHALL wrap modulo 2^ROB_WIDTH; tag comparison SHALL be exact equality only.
REQ-026 With readyIn low, all inputs other than the read ports SHALL be ignored.

Reset
REQ-027 While resetIn is low, all values SHALL be 0, busy SHALL be 0 and tags SHALL be 0, effective immediately without waiting for a clock edge.
REQ-028 Reset SHALL take priority over clear, commit and rename; a reset asserted mid-rename SHALL leave the register not busy.
REQ-029 Reads during reset SHALL return ready=1, value=0.

Structure
REQ-030 The register count (32), register-index width (5) and data width (32) SHALL be constants in the shared CPU package; ROB_WIDTH SHALL remain a parameter.
REQ-031 No sub-module; the two read ports SHALL be generated from one read-resolve function.

Verification
REQ-032 Reset, then read x5 -> ready=1, value=0, rs1Dep=0.
REQ-033 Rename x5->tag 3 with robRs1Ready=0 -> rs1Ready=0, rs1Dep=3; set robRs1Ready=1, robRs1Value=0xDEAD -> rs1Ready=1, rs1Value=0xDEAD.
REQ-034 Commit x5=0x1234 tag 3 -> same-cycle read gives 0x1234 ready (bypass); next cycle x5 not busy, value 0x1234.
REQ-035 Rename x7->2, rename x7->9, commit x7 tag 2 value 0x55 -> x7 stays busy with tag 9 and value 0x55.
REQ-036 Renames x1->1 and x2->4, then clear together with rename x3->5 -> x1, x2 and x3 all not busy.
REQ-037 Rename x0->6 and commit x0=0xFF -> x0 reads ready with value 0; pulse resetIn low mid-run -> all registers read 0 and ready immediately.
